security_fpga: RTL and testbench
================================

# security_fpga

Three-FIFO encrypt/decrypt loopback datapath for on-chip security checking. Plaintext words enter an input FIFO. Each popped word is encrypted with a 32-bit key and presented on `data_out`. A software-style controller writes ciphertext back into a cipher FIFO; popped ciphertext is decrypted into an output FIFO, whose head is presented on `data_out_final`. All FIFO pushes and pops are driven externally, so the sequencing controller sits above this block.

## Interface
- `DATA_W`, 32: word width; `key` width equals `DATA_W`.
- `FIFO_DEPTH`, 8: entries per FIFO, power of two, ≥2.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: one clock; reset is synchronous and active-high. The port keeps the codebase name; it is asserted at 1.
- `data_in` in 32: plaintext word pushed into FIFO2.
- `key` in 32: cipher key, sampled combinationally at each encrypt/decrypt register load.
- `wr2` / `rd2` in 1: push `data_in` into / pop FIFO2 (input, plaintext).
- `wr1` / `rd1` in 1: push `data_out` into / pop FIFO1 (cipher).
- `wr3` / `rd3` in 1: push decrypted word into / pop FIFO3 (output, plaintext).
- `data_out` out 32: registered ciphertext of the last word popped from FIFO2.
- `data_out_final` out 32: registered last word popped from FIFO3.
- `full` out 1: FIFO2 full.
- `empty` out 1: FIFO3 empty.

## Operation
- Cipher, with `r = key[4:0]`:
  - `enc(p) = rotl(p ^ key, r)`
  - `dec(c) = rotr(c, r) ^ key`
  - `dec(enc(p)) == p` for any key.
- Pop FIFO2 (`rd2` and FIFO2 not empty): `data_out <= enc(head2)`.
- Pop FIFO1 (`rd1` and FIFO1 not empty): internal `dec_reg <= dec(head1)`.
- `wr1` pushes the current `data_out`; `wr3` pushes the current `dec_reg`.
- Pop FIFO3 (`rd3` and FIFO3 not empty): `data_out_final <= head3`.
- Push to a full FIFO: dropped; pointers and count unchanged.
- Pop from an empty FIFO: ignored; the associated output register holds its value.
- Simultaneous push+pop on a non-empty FIFO: both performed, count unchanged. Simultaneous push+pop on a full FIFO is legal, since the pop frees the slot.
- Simultaneous push+pop on an empty FIFO: push only, no fall-through.
- Pointers wrap modulo `FIFO_DEPTH`; each FIFO keeps a count of width `clog2(DEPTH)+1`.
- Reset values:
  - `data_out`, `dec_reg`, `data_out_final`: 0
  - all pointers and counts: 0
  - `empty`: 1
  - `full`: 0
- Reset has priority over every strobe and may occur mid-sequence; stored words are discarded.

## Timing
- Strobes are sampled at the rising edge; each asserted cycle is one push or pop.
- Pop→output latency is 1 cycle: the value is valid after the popping edge.
- `data_out` is pushable by `wr1` from the next cycle. The same applies to `dec_reg` and `wr3`.
- Full plaintext→final path needs at least 6 edges: wr2, rd2, wr1, rd1, wr3, rd3.
- `full` and `empty` are registered-state derived and update in the cycle after the causing edge.
- `key` changes take effect at the next load edge and do not retro-affect stored words.

## Structure
- Package `security_pkg`: `DATA_W`, `FIFO_DEPTH`, functions `enc`/`dec`/`rotl`/`rotr`.
- Sub-module `sync_fifo` (parameters `DATA_W`, `DEPTH`; ports `clk`, `rst_n`, `wr`, `rd`, `din`, `dout` = head, `empty`, `full`), instantiated three times.
- The top level holds the three output registers and the cipher logic.

## Test plan
- Reset: assert `rst_n`=1 for 2 cycles → `data_out`=0, `data_out_final`=0, `empty`=1, `full`=0. Strobes during reset have no effect.
- Loopback: `key`=0xC0000001; push 0x0078696E then 0x6368616F.
  - rd2 → `data_out`=0x80F0D2DF; wr1.
  - rd2 → `data_out`=0x46D0C2DD; wr1.
  - rd1, wr3 twice → `empty`=0.
  - rd3 → `data_out_final`=0x0078696E, then 0x6368616F → `empty`=1.
- Full: push 9 words into FIFO2 → `full`=1 after the 8th push; the 9th is dropped; 8 pops return words 1–8 in order.
- Underflow: rd2/rd3 on empty FIFOs → outputs hold their previous values, counts stay 0.
- Wrap and simultaneous: interleave push+pop on FIFO1 across 20 cycles at count 3 → order preserved, count constant. Push+pop on empty → count becomes 1, outputs unchanged.
- Key sweep: for `r` = 0, 1, 31 with random keys and data → `data_out_final` equals the original plaintext.

Source files
------------

// File: rtl/security_pkg.sv
// Shared widths and the rotate-xor cipher used by the security loopback datapath.
// enc/dec are exact inverses for every key: the rotate amount is key[4:0].
package security_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int ROT_W      = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                             input logic [ROT_W-1:0]  r);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} << r;
    return dbl[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input logic [ROT_W-1:0]  r);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} >> r;
    return dbl[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] enc(input logic [DATA_W-1:0] p,
                                            input logic [DATA_W-1:0] key);
    return rotl(p ^ key, key[ROT_W-1:0]);
  endfunction

  function automatic logic [DATA_W-1:0] dec(input logic [DATA_W-1:0] c,
                                            input logic [DATA_W-1:0] key);
    return rotr(c, key[ROT_W-1:0]) ^ key;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; overflow pushes and underflow pops are ignored.
// A pop frees a slot in the same edge, so push+pop while full is accepted.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = rd && !empty;
    do_push  = wr && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; clearing the pointers discards stored words.
  always_ff @(posedge clk) begin
    if (do_push && !rst_n) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/security_fpga.sv
// Encrypt/decrypt loopback: FIFO2 (plaintext in) -> enc -> FIFO1 (cipher) -> dec -> FIFO3 (plaintext out).
// All push/pop strobes come from an external sequencer; rst_n is active-high despite its name.
module security_fpga
  import security_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] key,
  input  logic              wr2,
  input  logic              rd2,
  input  logic              wr1,
  input  logic              rd1,
  input  logic              wr3,
  input  logic              rd3,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_out_final,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] head2, head1, head3;
  logic              f2_empty, f1_empty;
  logic              unused_f1_full, unused_f3_full;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] dec_q, dec_d;
  logic [DATA_W-1:0] final_q, final_d;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(clk), .rst_n(rst_n), .wr(wr2), .rd(rd2), .din(data_in),
    .dout(head2), .empty(f2_empty), .full(full)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .wr(wr1), .rd(rd1), .din(data_out_q),
    .dout(head1), .empty(f1_empty), .full(unused_f1_full)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo3 (
    .clk(clk), .rst_n(rst_n), .wr(wr3), .rd(rd3), .din(dec_q),
    .dout(head3), .empty(empty), .full(unused_f3_full)
  );

  // Key is sampled only at the loading edge; words already queued keep the old key's result.
  always_comb begin
    data_out_d = data_out_q;
    dec_d      = dec_q;
    final_d    = final_q;
    if (rd2 && !f2_empty) data_out_d = enc(head2, key);
    if (rd1 && !f1_empty) dec_d      = dec(head1, key);
    if (rd3 && !empty)    final_d    = head3;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      data_out_q <= '0;
      dec_q      <= '0;
      final_q    <= '0;
    end else begin
      data_out_q <= data_out_d;
      dec_q      <= dec_d;
      final_q    <= final_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_final = final_q;

endmodule

// File: tb/tb_security_fpga.sv
// Directed + random bench for security_fpga against a queue-based reference model.
module tb_security_fpga;

  logic        clk = 1'b0;
  logic        rst_n, wr1, rd1, wr2, rd2, wr3, rd3;
  logic [31:0] data_in, key;
  logic [31:0] data_out, data_out_final;
  logic        full, empty;

  always #5 clk = ~clk;

  security_fpga dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .key(key),
    .wr2(wr2), .rd2(rd2), .wr1(wr1), .rd1(rd1), .wr3(wr3), .rd3(rd3),
    .data_out(data_out), .data_out_final(data_out_final),
    .full(full), .empty(empty)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] q1[$], q2[$], q3[$];
  logic [31:0] m_out = 0, m_dec = 0, m_fin = 0;
  logic [31:0] words[9];

  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int r);
    for (int i = 0; i < r; i++) x = {x[30:0], x[31]};
    return x;
  endfunction

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int r);
    for (int i = 0; i < r; i++) x = {x[0], x[31:1]};
    return x;
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] p, input logic [31:0] k);
    return m_rotl(p ^ k, int'(k % 32));
  endfunction

  function automatic logic [31:0] m_decf(input logic [31:0] c, input logic [31:0] k);
    return m_rotr(c, int'(k % 32)) ^ k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive strobes, advance the model at the edge, then compare.
  task automatic step(input logic r, input logic w2, input logic p2, input logic w1,
                      input logic p1, input logic w3, input logic p3, input logic [31:0] d);
    logic [31:0] n_out, n_dec, n_fin, push1, push3;
    logic        pop1, pop2, pop3;
    rst_n = r; wr2 = w2; rd2 = p2; wr1 = w1; rd1 = p1; wr3 = w3; rd3 = p3; data_in = d;
    @(posedge clk);
    if (r) begin
      q1.delete(); q2.delete(); q3.delete();
      m_out = 0; m_dec = 0; m_fin = 0;
    end else begin
      pop2 = p2 && q2.size() > 0;
      pop1 = p1 && q1.size() > 0;
      pop3 = p3 && q3.size() > 0;
      n_out = pop2 ? m_enc(q2[0], key) : m_out;
      n_dec = pop1 ? m_decf(q1[0], key) : m_dec;
      n_fin = pop3 ? q3[0] : m_fin;
      push1 = m_out;
      push3 = m_dec;
      if (pop2) void'(q2.pop_front());
      if (pop1) void'(q1.pop_front());
      if (pop3) void'(q3.pop_front());
      if (w2 && q2.size() < 8) q2.push_back(d);
      if (w1 && q1.size() < 8) q1.push_back(push1);
      if (w3 && q3.size() < 8) q3.push_back(push3);
      m_out = n_out; m_dec = n_dec; m_fin = n_fin;
    end
    #1;
    chk("data_out", data_out, m_out);
    chk("data_out_final", data_out_final, m_fin);
    chk("full", {31'b0, full}, {31'b0, q2.size() == 8});
    chk("empty", {31'b0, empty}, {31'b0, q3.size() == 0});
  endtask

  initial begin
    rst_n = 1; wr1 = 0; rd1 = 0; wr2 = 0; rd2 = 0; wr3 = 0; rd3 = 0;
    data_in = 0; key = 0;

    // Reset with every strobe asserted
    step(1, 1, 1, 1, 1, 1, 1, $urandom);
    step(1, 1, 1, 1, 1, 1, 1, $urandom);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_final", data_out_final, 32'h0);
    chk("rst_empty", {31'b0, empty}, 32'h1);
    chk("rst_full", {31'b0, full}, 32'h0);
    step(0, 0, 1, 0, 1, 0, 1, 0);
    chk("post_rst_pop", data_out, 32'h0);

    // Known-answer loopback
    key = 32'hC0000001;
    step(0, 1, 0, 0, 0, 0, 0, 32'h0078696E);
    step(0, 1, 0, 0, 0, 0, 0, 32'h6368616F);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("lb_enc0", data_out, 32'h80F0D2DF);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("lb_enc1", data_out, 32'h46D0C2DD);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("lb_not_empty", {31'b0, empty}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("lb_final0", data_out_final, 32'h0078696E);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("lb_final1", data_out_final, 32'h6368616F);
    chk("lb_empty", {31'b0, empty}, 32'h1);

    // FIFO2 fill to full, overflow drop, ordered drain
    step(1, 0, 0, 0, 0, 0, 0, 0);
    key = $urandom;
    for (int i = 0; i < 9; i++) begin
      words[i] = $urandom;
      step(0, 1, 0, 0, 0, 0, 0, words[i]);
      if (i >= 7) chk("full_set", {31'b0, full}, 32'h1);
      else        chk("full_clr", {31'b0, full}, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, 0);
      chk("drain_order", data_out, m_enc(words[i], key));
    end

    // Underflow: pops on empty FIFOs hold outputs
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    chk("uflow_hold", data_out, m_enc(words[7], key));
    chk("uflow_final", data_out_final, 32'h0);

    // Steady push+pop on every FIFO with FIFO1 held at three entries
    step(1, 0, 0, 0, 0, 0, 0, 0);
    key = $urandom;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 1, 1, i > 0, i > 1, $urandom);
      chk("q1_count", q1.size(), 3);
    end

    // Push+pop on an empty FIFO3: push only
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    chk("pp_empty_final", data_out_final, 32'h0);
    chk("pp_empty_flag", {31'b0, empty}, 32'h0);

    // Key sweep over rotate amounts 0, 1, 31
    for (int j = 0; j < 3; j++) begin
      logic [31:0] p;
      logic [4:0]  rr;
      rr = (j == 0) ? 5'd0 : (j == 1) ? 5'd1 : 5'd31;
      key = {$urandom_range(32'h07FFFFFF, 0), rr};
      p = $urandom;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, p);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      chk("sweep_roundtrip", data_out_final, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
